tpu_mac_banked: RTL and testbench
=================================

TPU_MAC_BANKED -- requirements
Module: tpu_mac_banked

Interface
REQ-001 SHALL have parameter EXP_W, default 4: exponent field width of each minifloat operand.
REQ-002 SHALL have parameter MAN_W, default 3: mantissa field width; operand width FMT_W = 1+EXP_W+MAN_W (default 8).
REQ-003 SHALL have parameter ACC_W, default 34: signed accumulator width; must be even; HALF_W = ACC_W/2.
REQ-004 SHALL have parameter BANKS, default 4: number of independent accumulators; BANK_AW = max(1, clog2(BANKS)).
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 in_valid  input  1  operand pair offered.
REQ-009 in_ready  output  1  operand pair can be accepted this cycle.
REQ-010 in_a, in_b  input  FMT_W each  operands: {sign, exp[EXP_W], man[MAN_W]}.
REQ-011 in_bank  input  BANK_AW  target accumulator for the pair.
REQ-012 clr  input  1  one-cycle pulse: zero all banks, flush pipeline, clear err/ovf.
REQ-013 rd_en, rd_bank, rd_hl  input  1/BANK_AW/1  read request, bank, half select (1 = upper).
REQ-014 rd_valid, rd_data  output  1/HALF_W  read response.
REQ-015 err, ovf, busy  output  1 each  sticky shift-range error, sticky accumulator overflow, pipeline occupied.

Function
REQ-016 Transfer occurs on a rising edge with in_valid & in_ready; in_ready = ~reset & ~clr (combinational); in_bank >= BANKS SHALL drop the pair.
REQ-017 Decode: norm = (exp != 0); significand = {norm, man} (MAN_W+1 bits); effective exponent E = exp - norm.
REQ-018 Stage 1 (registered on transfer edge): unsigned product P = sigA*sigB, shift S = EA+EB, sign = signA ^ signB, bank, valid.
REQ-019 Stage 2 (next edge): value = P << S; if value needs more than ACC_W-1 bits, contribution SHALL be 0 and err SHALL set; else bank += (sign ? -value : value).
REQ-020 Back-to-back pairs to the same bank SHALL each be accumulated exactly once (read-modify-write within stage 2, no stall).
REQ-021 Latency: pair transferred on edge k updates its bank on edge k+1; a rd_en sampled on edge k+2 or later returns the updated value.
REQ-022 Read: rd_en sampled on edge r -> rd_valid=1 and rd_data = bank[rd_bank][rd_hl ? ACC_W-1:HALF_W : HALF_W-1:0] after edge r; rd_valid=0 otherwise.
REQ-023 Read and stage-2 write to same bank on the same edge SHALL return the pre-write value; rd_bank >= BANKS returns 0 with rd_valid=1.
REQ-024 Signed overflow of a bank update SHALL set ovf (sticky); wrap vs saturate per REQ-030.
REQ-025 busy = stage-1 valid register.
REQ-026 clr on an edge SHALL zero all banks, discard the stage-1 entry (no update from it), and clear err, ovf; clr overrides a simultaneous stage-2 write; a simultaneous rd_en returns pre-clear value.

Reset
REQ-027 reset on an edge SHALL zero all banks, stage-1 registers, err, ovf, rd_valid, rd_data; busy=0.
REQ-028 reset mid-operation SHALL discard any in-flight pair; reset dominates clr and in_valid.
REQ-029 in_ready SHALL be 0 in any cycle reset is high.

Configuration
REQ-030 Macro TPU_MAC_SAT_EN: defined -> overflowing update saturates to 2^(ACC_W-1)-1 or -2^(ACC_W-1); undefined -> two's-complement wrap; ovf behaves identically in both.

Verification
REQ-031 Defaults, in_a=0x08, in_b=0x08, bank 0; read bank 0 low -> rd_data=64, high -> 0, err=0.
REQ-032 Then in_a=0x88, in_b=0x08 bank 0 on next cycle (back-to-back) -> bank 0 low reads 0; banks 1-3 read 0.
REQ-033 in_a=0x7F, in_b=0x7F -> err=1, bank unchanged; clr -> err=0, all banks 0.
REQ-034 Two pairs 0x70*0x70 to bank 2 -> with TPU_MAC_SAT_EN bank = 2^33-1 (high 0xFFFF, low 0x1FFFF truncated to HALF_W=17 bits), ovf=1; without -> bank = -2^33, ovf=1.
REQ-035 Pair transferred, reset asserted next cycle -> bank stays 0, busy=0, rd_valid=0.
REQ-036 clr coincident with stage-2 write to bank 1 -> bank 1 reads 0 afterwards.

Source files
------------

// File: rtl/tpu_mac_banked.sv
// rtl/tpu_mac_banked.sv - two-stage minifloat multiply into banked signed accumulators
// Optional macro TPU_MAC_SAT_EN: saturate overflowing bank updates instead of wrapping.
module tpu_mac_banked #(
    parameter  int EXP_W   = 4,
    parameter  int MAN_W   = 3,
    parameter  int ACC_W   = 34,
    parameter  int BANKS   = 4,
    localparam int FMT_W   = 1 + EXP_W + MAN_W,
    localparam int HALF_W  = ACC_W / 2,
    localparam int BANK_AW = (BANKS > 1) ? $clog2(BANKS) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FMT_W-1:0]   in_a,
    input  logic [FMT_W-1:0]   in_b,
    input  logic [BANK_AW-1:0] in_bank,
    input  logic               clr,
    input  logic               rd_en,
    input  logic [BANK_AW-1:0] rd_bank,
    input  logic               rd_hl,
    output logic               rd_valid,
    output logic [HALF_W-1:0]  rd_data,
    output logic               err,
    output logic               ovf,
    output logic               busy
);

    localparam int SIG_W  = MAN_W + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam int SH_W   = EXP_W + 1;
    localparam int WIDE_W = PROD_W + (1 << SH_W) + ACC_W;
    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W-1:0]   bank_q [BANKS];
    logic               s1_valid_q, s1_valid_d;
    logic [PROD_W-1:0]  s1_prod_q, s1_prod_d;
    logic [SH_W-1:0]    s1_shift_q, s1_shift_d;
    logic               s1_sign_q, s1_sign_d;
    logic [BANK_AW-1:0] s1_bank_q, s1_bank_d;
    logic               err_q, ovf_q, rd_valid_q;
    logic [HALF_W-1:0]  rd_data_q, rd_data_d;

    logic               norm_a, norm_b;
    logic [SIG_W-1:0]   sig_a, sig_b;
    logic [EXP_W-1:0]   e_a, e_b;
    logic [WIDE_W-1:0]  wide;
    logic               range_err, upd, sum_ovf;
    logic [ACC_W-1:0]   mag, addend, cur, bank_d;
    logic [ACC_W:0]     sum;
    logic [ACC_W-1:0]   rd_word;

    assign in_ready = ~reset & ~clr;

    // Stage 1: decode both operands and form the product and combined shift.
    always_comb begin
        norm_a     = |in_a[EXP_W+MAN_W-1:MAN_W];
        norm_b     = |in_b[EXP_W+MAN_W-1:MAN_W];
        sig_a      = {norm_a, in_a[MAN_W-1:0]};
        sig_b      = {norm_b, in_b[MAN_W-1:0]};
        e_a        = in_a[EXP_W+MAN_W-1:MAN_W] - EXP_W'(norm_a);
        e_b        = in_b[EXP_W+MAN_W-1:MAN_W] - EXP_W'(norm_b);
        s1_valid_d = in_valid & in_ready &
                     ({1'b0, in_bank} < (BANK_AW+1)'(BANKS));
        s1_prod_d  = PROD_W'(sig_a) * PROD_W'(sig_b);
        s1_shift_d = {1'b0, e_a} + {1'b0, e_b};
        s1_sign_d  = in_a[FMT_W-1] ^ in_b[FMT_W-1];
        s1_bank_d  = in_bank;
    end

    // Stage 2: align, range-check and read-modify-write the target bank.
    always_comb begin
        wide      = WIDE_W'(s1_prod_q) << s1_shift_q;
        range_err = |wide[WIDE_W-1:ACC_W-1];
        mag       = {1'b0, wide[ACC_W-2:0]};
        addend    = s1_sign_q ? -mag : mag;
        cur       = bank_q[s1_bank_q];
        sum       = {cur[ACC_W-1], cur} + {addend[ACC_W-1], addend};
        sum_ovf   = sum[ACC_W] ^ sum[ACC_W-1];
        upd       = s1_valid_q & ~range_err;
`ifdef TPU_MAC_SAT_EN
        bank_d    = sum_ovf ? (cur[ACC_W-1] ? SAT_MIN : SAT_MAX) : sum[ACC_W-1:0];
`else
        bank_d    = sum[ACC_W-1:0];
`endif
    end

    always_comb begin
        rd_word = '0;
        if ({1'b0, rd_bank} < (BANK_AW+1)'(BANKS)) begin
            rd_word = bank_q[rd_bank];
        end
        rd_data_d = rd_hl ? rd_word[ACC_W-1:HALF_W] : rd_word[HALF_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            s1_valid_q <= 1'b0;
            s1_prod_q  <= '0;
            s1_shift_q <= '0;
            s1_sign_q  <= 1'b0;
            s1_bank_q  <= '0;
            err_q      <= 1'b0;
            ovf_q      <= 1'b0;
            for (int i = 0; i < BANKS; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_prod_q  <= s1_prod_d;
            s1_shift_q <= s1_shift_d;
            s1_sign_q  <= s1_sign_d;
            s1_bank_q  <= s1_bank_d;
            err_q      <= err_q | (s1_valid_q & range_err);
            ovf_q      <= ovf_q | (upd & sum_ovf);
            if (upd) begin
                bank_q[s1_bank_q] <= bank_d;
            end
        end
    end

    // Reads sample the banks before any same-edge write or clear lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_data_q <= rd_data_d;
            end
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign err      = err_q;
    assign ovf      = ovf_q;
    assign busy     = s1_valid_q;

endmodule

// File: tb/tb_tpu_mac_banked.sv
// tb/tb_tpu_mac_banked.sv - scoreboard bench for tpu_mac_banked with directed vectors
module tb_tpu_mac_banked;
    localparam int HW = 17;

    logic          clk = 1'b0;
    logic          reset, in_valid, in_ready, clr, rd_en, rd_hl, rd_valid, err, ovf, busy;
    logic [7:0]    in_a, in_b;
    logic [1:0]    in_bank, rd_bank;
    logic [HW-1:0] rd_data;

    int            tests = 0;
    int            fails = 0;
    logic [HW-1:0] exp_q [$];
    logic [HW-1:0] mon_exp;

    always #5 clk = ~clk;

    tpu_mac_banked dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_bank(in_bank), .clr(clr),
        .rd_en(rd_en), .rd_bank(rd_bank), .rd_hl(rd_hl),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .err(err), .ovf(ovf), .busy(busy)
    );

    // Monitor: every read response is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL rd_unexpected: got %0h with no expected read", rd_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (rd_data !== mon_exp) begin
                    fails++;
                    $display("FAIL rd_data: got %0h expected %0h", rd_data, mon_exp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pair(input logic [7:0] a, input logic [7:0] b, input logic [1:0] bank);
        in_a = a; in_b = b; in_bank = bank; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic rd(input logic [1:0] bank, input logic hl, input logic [HW-1:0] e);
        rd_bank = bank; rd_hl = hl; rd_en = 1'b1;
        exp_q.push_back(e);
        step();
        rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        #1;
        check("in_ready_clr", in_ready, 0);
        step();
        clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; clr = 1'b0; in_valid = 1'b0; rd_en = 1'b0;
        rd_hl = 1'b0; rd_bank = '0; in_a = '0; in_b = '0; in_bank = '0;
        step();
        in_valid = 1'b1; in_a = 8'h08; in_b = 8'h08;
        step();
        check("in_ready_reset", in_ready, 0);
        check("busy_reset", busy, 0);
        check("err_reset", err, 0);
        check("ovf_reset", ovf, 0);
        check("rd_valid_reset", rd_valid, 0);
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("in_ready_idle", in_ready, 1);

        pair(8'h08, 8'h08, 2'd0);
        check("busy_after_transfer", busy, 1);
        idle(1);
        check("busy_drained", busy, 0);
        check("err_small", err, 0);
        rd(2'd0, 1'b0, 17'd64);
        rd(2'd0, 1'b1, 17'd0);

        pair(8'h88, 8'h08, 2'd0);
        idle(1);
        rd(2'd0, 1'b0, 17'd0);

        pair(8'h08, 8'h08, 2'd1);
        pair(8'h08, 8'h08, 2'd1);
        pair(8'h88, 8'h08, 2'd1);
        idle(1);
        rd(2'd1, 1'b0, 17'd64);

        pair(8'h38, 8'h08, 2'd2);
        pair(8'h09, 8'h01, 2'd3);
        idle(1);
        rd(2'd2, 1'b0, 17'd4096);
        rd(2'd3, 1'b0, 17'd9);

        pair(8'h88, 8'h08, 2'd0);
        idle(1);
        rd(2'd0, 1'b0, 17'h1FFC0);
        rd(2'd0, 1'b1, 17'h1FFFF);

        pair(8'h7F, 8'h7F, 2'd2);
        idle(1);
        check("err_range", err, 1);
        check("ovf_no_range", ovf, 0);
        rd(2'd2, 1'b0, 17'd4096);

        pulse_clr();
        check("err_cleared", err, 0);
        for (int b = 0; b < 4; b++) begin
            rd(2'(b), 1'b0, 17'd0);
            rd(2'(b), 1'b1, 17'd0);
        end

        pair(8'h70, 8'h70, 2'd2);
        idle(1);
        check("err_edge_fit", err, 0);
        check("ovf_edge_fit", ovf, 0);
        rd(2'd2, 1'b1, 17'h08000);
        rd(2'd2, 1'b0, 17'd0);
        pair(8'h70, 8'h70, 2'd2);
        idle(1);
        check("ovf_set", ovf, 1);
        check("err_no_range", err, 0);
`ifdef TPU_MAC_SAT_EN
        rd(2'd2, 1'b1, 17'h0FFFF);
        rd(2'd2, 1'b0, 17'h1FFFF);
`else
        rd(2'd2, 1'b1, 17'h10000);
        rd(2'd2, 1'b0, 17'd0);
`endif
        pulse_clr();
        check("ovf_cleared", ovf, 0);

        pair(8'h08, 8'h08, 2'd1);
        rd(2'd1, 1'b0, 17'd0);
        rd(2'd1, 1'b0, 17'd64);

        pair(8'h08, 8'h08, 2'd1);
        clr = 1'b1; rd_bank = 2'd1; rd_hl = 1'b0; rd_en = 1'b1;
        exp_q.push_back(17'd64);
        step();
        clr = 1'b0; rd_en = 1'b0;
        check("busy_after_clr", busy, 0);
        rd(2'd1, 1'b0, 17'd0);

        pair(8'h08, 8'h08, 2'd3);
        reset = 1'b1;
        step();
        check("busy_after_reset", busy, 0);
        check("rd_valid_after_reset", rd_valid, 0);
        reset = 1'b0;
        idle(1);
        rd(2'd3, 1'b0, 17'd0);

        idle(2);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
